// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending bit,
// optional write-to-read forwarding and a one-register-per-cycle hardware clear.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b_i,
    output logic [XLEN-1:0]          rd_data_a_o,
    output logic [XLEN-1:0]          rd_data_b_o,
    output logic                     rd_busy_a_o,
    output logic                     rd_busy_b_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [XLEN-1:0]          wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [$clog2(DEPTH)-1:0] rsv_addr_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int NUM_PORTS = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;

    logic idle;
    logic wr_ok;
    logic rsv_ok;

    assign idle = (state_q == ST_IDLE);
    // Writes and reservations to a hardwired zero, or while clearing, never land.
    assign wr_ok  = wr_en_i  && idle && !((ZERO_REG != 0) && (wr_addr_i  == '0));
    assign rsv_ok = rsv_en_i && idle && !((ZERO_REG != 0) && (rsv_addr_i == '0));

    always_comb begin
        mem_d   = mem_q;
        pend_d  = pend_q;
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_CLEAR) begin
            mem_d[idx_q]  = '0;
            pend_d[idx_q] = 1'b0;
            idx_d         = idx_q + 1'b1;
            if (idx_q == AW'(DEPTH - 1)) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        end else begin
            if (wr_ok) begin
                mem_d[wr_addr_i]  = wr_data_i;
                pend_d[wr_addr_i] = 1'b0;
            end
            // Applied after the write so a same-address reservation wins.
            if (rsv_ok) begin
                pend_d[rsv_addr_i] = 1'b1;
            end
            if (clr_req_i) begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q  <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    logic [NUM_PORTS-1:0][AW-1:0]   rd_addr;
    logic [NUM_PORTS-1:0][XLEN-1:0] rd_data;
    logic [NUM_PORTS-1:0]           rd_busy;

    assign rd_addr = {rd_addr_b_i, rd_addr_a_i};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic zero_hit;
        logic byp_hit;
        assign zero_hit = (ZERO_REG != 0) && (rd_addr[p] == '0);
        assign byp_hit  = (BYPASS != 0) && wr_ok && (wr_addr_i == rd_addr[p]);
        always_comb begin
            rd_data[p] = mem_q[rd_addr[p]];
            rd_busy[p] = pend_q[rd_addr[p]];
            if (zero_hit) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if (byp_hit) begin
                rd_data[p] = wr_data_i;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rd_data_a_o = rd_data[0];
    assign rd_data_b_o = rd_data[1];
    assign rd_busy_a_o = rd_busy[0];
    assign rd_busy_b_o = rd_busy[1];
    assign clr_busy_o  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random and directed checks of two register-file configurations against
// an array-based model of the register/pending/clear rules.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  ra_a [2];
    logic [4:0]  ra_b [2];
    logic [4:0]  wa   [2];
    logic [4:0]  rsa  [2];
    logic        we   [2];
    logic        rsv  [2];
    logic        clr  [2];
    logic [63:0] wd   [2];

    wire [31:0] da0, db0;
    wire [63:0] da1, db1;
    wire ba0, bb0, ba1, bb1, cb0, cb1;

    int nvec = 0;
    int nerr = 0;

    regfile_scoreboard u_dut0 (
        .clock_i(clk), .reset_n_i(rst_n),
        .rd_addr_a_i(ra_a[0]), .rd_addr_b_i(ra_b[0]),
        .rd_data_a_o(da0), .rd_data_b_o(db0),
        .rd_busy_a_o(ba0), .rd_busy_b_o(bb0),
        .wr_en_i(we[0]), .wr_addr_i(wa[0]), .wr_data_i(wd[0][31:0]),
        .rsv_en_i(rsv[0]), .rsv_addr_i(rsa[0]),
        .clr_req_i(clr[0]), .clr_busy_o(cb0)
    );

    regfile_scoreboard #(.XLEN(64), .DEPTH(16), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
        .clock_i(clk), .reset_n_i(rst_n),
        .rd_addr_a_i(ra_a[1][3:0]), .rd_addr_b_i(ra_b[1][3:0]),
        .rd_data_a_o(da1), .rd_data_b_o(db1),
        .rd_busy_a_o(ba1), .rd_busy_b_o(bb1),
        .wr_en_i(we[1]), .wr_addr_i(wa[1][3:0]), .wr_data_i(wd[1]),
        .rsv_en_i(rsv[1]), .rsv_addr_i(rsa[1][3:0]),
        .clr_req_i(clr[1]), .clr_busy_o(cb1)
    );

    // Model: config 0 = 32x32 zero-reg + bypass, config 1 = 16x64 plain.
    logic [63:0] m_mem  [2][32];
    bit          m_pend [2][32];
    int          m_cnt  [2];

    function automatic int dep(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_data(int d, logic [4:0] a);
        if (d == 0 && a == 0) return 64'd0;
        if (d == 0 && we[d] && m_cnt[d] == 0 && wa[d] == a) return {32'd0, wd[d][31:0]};
        return m_mem[d][a];
    endfunction

    function automatic logic exp_busy(int d, logic [4:0] a);
        if (d == 0 && a == 0) return 1'b0;
        if (d == 0 && we[d] && m_cnt[d] == 0 && wa[d] == a) return 1'b0;
        return m_pend[d][a];
    endfunction

    task automatic check_all();
        chk("rd_a0", {32'd0, da0}, exp_data(0, ra_a[0]));
        chk("rd_b0", {32'd0, db0}, exp_data(0, ra_b[0]));
        chk("bz_a0", 64'(ba0), 64'(exp_busy(0, ra_a[0])));
        chk("bz_b0", 64'(bb0), 64'(exp_busy(0, ra_b[0])));
        chk("cb0",   64'(cb0), 64'(m_cnt[0] > 0));
        chk("rd_a1", da1, exp_data(1, ra_a[1]));
        chk("rd_b1", db1, exp_data(1, ra_b[1]));
        chk("bz_a1", 64'(ba1), 64'(exp_busy(1, ra_a[1])));
        chk("bz_b1", 64'(bb1), 64'(exp_busy(1, ra_b[1])));
        chk("cb1",   64'(cb1), 64'(m_cnt[1] > 0));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[d][i]  = 64'd0;
                m_pend[d][i] = 1'b0;
            end
            m_cnt[d] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (m_cnt[d] > 0) begin
                m_mem[d][dep(d) - m_cnt[d]]  = 64'd0;
                m_pend[d][dep(d) - m_cnt[d]] = 1'b0;
                m_cnt[d]--;
            end else begin
                if (we[d] && !(d == 0 && wa[d] == 0)) begin
                    m_mem[d][wa[d]]  = (d == 0) ? {32'd0, wd[d][31:0]} : wd[d];
                    m_pend[d][wa[d]] = 1'b0;
                end
                if (rsv[d] && !(d == 0 && rsa[d] == 0)) m_pend[d][rsa[d]] = 1'b1;
                if (clr[d]) m_cnt[d] = dep(d);
            end
        end
    endtask

    // Called just after a falling edge with inputs driven.
    task automatic tick();
        #1;
        check_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(int d, bit rnd, bit allow_clr);
        int mx;
        mx = dep(d) - 1;
        ra_a[d] = 5'($urandom_range(0, mx));
        ra_b[d] = 5'($urandom_range(0, mx));
        wa[d]   = 5'($urandom_range(0, mx));
        rsa[d]  = 5'($urandom_range(0, mx));
        wd[d]   = (d == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
        we[d]   = rnd && ($urandom_range(0, 1) == 1);
        rsv[d]  = rnd && ($urandom_range(0, 2) == 0);
        clr[d]  = rnd && allow_clr && ($urandom_range(0, 49) == 0);
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
    endtask

    // Entered just after a falling edge; returns just after a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        idle_all();
        #1;
        chk("rst_cb0", 64'(cb0), 64'd0);
        chk("rst_cb1", 64'(cb1), 64'd0);
        for (int a = 0; a < 32; a++) begin
            ra_a[0] = 5'(a);
            ra_b[0] = 5'(31 - a);
            ra_a[1] = 5'(a % 16);
            ra_b[1] = 5'(15 - (a % 16));
            #1;
            check_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_window(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, cb0, 1'b0);
            drive(1, cb1, 1'b0);
            if (cb0) n0++;
            if (cb1) n1++;
            if (i >= 1 && i <= 32) begin
                ra_b[0] = 5'(i - 1);
                #1;
                chk("clr_done", {32'd0, db0}, 64'd0);
            end
            if (i >= 1 && i <= 31) begin
                ra_a[0] = 5'(i);
                #1;
                chk("clr_pend", {32'd0, da0}, 64'(i * 3));
            end
            tick();
        end
    endtask

    initial begin
        int n0, n1;
        idle_all();
        model_reset();
        @(negedge clk);
        do_reset();

        // Parameter sweep: reg 0 writable, no same-cycle forwarding.
        idle_all();
        we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 64'hA5A5_5A5A_0123_4567; ra_a[1] = 5'd0;
        #1 chk("nobyp_old", da1, 64'd0);
        tick();
        idle_all();
        ra_a[1] = 5'd0;
        #1 chk("nobyp_new", da1, 64'hA5A5_5A5A_0123_4567);
        tick();

        idle_all();
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 64'hDEAD_BEEF; ra_a[0] = 5'd5;
        #1 chk("byp_same", {32'd0, da0}, 64'hDEAD_BEEF);
        tick();
        idle_all();
        ra_a[0] = 5'd5;
        #1 chk("byp_held", {32'd0, da0}, 64'hDEAD_BEEF);
        tick();

        idle_all();
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 64'h1234; ra_b[0] = 5'd0;
        tick();
        idle_all();
        ra_a[0] = 5'd0;
        #1 chk("zero_reg", {32'd0, da0}, 64'd0);
        tick();

        idle_all();
        rsv[0] = 1'b1; rsa[0] = 5'd7;
        tick();
        idle_all();
        ra_a[0] = 5'd7;
        #1 chk("rsv_busy", 64'(ba0), 64'd1);
        tick();
        idle_all();
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 64'h77; ra_a[0] = 5'd1;
        tick();
        idle_all();
        ra_a[0] = 5'd7;
        #1 chk("wr_unbusy", 64'(ba0), 64'd0);
        chk("wr_data7", {32'd0, da0}, 64'h77);
        tick();
        idle_all();
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 64'h99; rsv[0] = 1'b1; rsa[0] = 5'd9;
        tick();
        idle_all();
        ra_a[0] = 5'd9;
        #1 chk("wr_rsv_data", {32'd0, da0}, 64'h99);
        chk("wr_rsv_busy", 64'(ba0), 64'd1);
        tick();

        // Fill, reserve, clear.
        for (int i = 0; i < 32; i++) begin
            idle_all();
            we[0] = 1'b1; wa[0] = 5'(i); wd[0] = 64'(i * 3);
            we[1] = 1'b1; wa[1] = 5'(i % 16); wd[1] = 64'(i * 3);
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            idle_all();
            rsv[0] = 1'b1; rsa[0] = 5'(i);
            rsv[1] = 1'b1; rsa[1] = 5'(i % 16);
            tick();
        end
        idle_all();
        clr[0] = 1'b1; clr[1] = 1'b1;
        tick();
        clear_window(n0, n1);
        chk("clr_len0", 64'(n0), 64'd32);
        chk("clr_len1", 64'(n1), 64'd16);
        idle_all();
        for (int a = 0; a < 32; a++) begin
            ra_a[0] = 5'(a);
            ra_a[1] = 5'(a % 16);
            #1;
            chk("end_d0", {32'd0, da0}, 64'd0);
            chk("end_b0", 64'(ba0), 64'd0);
            chk("end_d1", da1, 64'd0);
            chk("end_b1", 64'(ba1), 64'd0);
        end
        @(negedge clk);

        // Reset during a clear, then a fresh full-length clear.
        idle_all();
        clr[0] = 1'b1; clr[1] = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, 1'b0);
            drive(1, 1'b1, 1'b0);
            tick();
        end
        do_reset();
        idle_all();
        clr[0] = 1'b1; clr[1] = 1'b1;
        tick();
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, cb0, 1'b0);
            drive(1, cb1, 1'b0);
            if (cb0) n0++;
            if (cb1) n1++;
            tick();
        end
        chk("reclr_len0", 64'(n0), 64'd32);
        chk("reclr_len1", 64'(n1), 64'd16);

        for (int i = 0; i < 600; i++) begin
            drive(0, 1'b1, 1'b1);
            drive(1, 1'b1, 1'b1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
